// File: rtl/mem_stage_sequencer.sv
// mem_stage_sequencer
//
// Purpose: multi-cycle sequencer for the MEM stage of the pipelined LC-3b.
// It takes the memory fields of the decoded control word held in EX/MEM and
// drives the data-cache port until every access of the instruction has
// completed. Single accesses (LDR, STR, LDB, STB, TRAP vector read) use one
// cache transaction. Indirect sequences (LDI, STI) first read a pointer and
// then access memory at that pointer. While an access is outstanding the
// upstream pipeline is stalled.
//
// Optional feature: define MEM_SEQ_STALL_CNT_EN to add the stall_cycles
// output, a saturating count of stalled cycles.
//
// Ports:
//   clk, rst          pipeline clock, synchronous active-high reset
//   valid, in_mem     EX/MEM holds a live instruction that needs memory
//   in_st             final access is a write
//   in_indirect       first access fetches a pointer (LDI/STI)
//   in_byte           final access is a byte store
//   addr, store_data  effective address and SR value from EX
//   dmem_*            data-cache request/response port
//   load_data         raw word forwarded to MEM/WB
//   mem_done          one-cycle completion pulse
//   stall             freezes if_id/id_ex/ex_mem and bubbles MEM/WB
//   stall_cycles      (MEM_SEQ_STALL_CNT_EN only) saturating stall counter

module mem_stage_sequencer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              in_mem,
    input  logic              in_st,
    input  logic              in_indirect,
    input  logic              in_byte,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic [ADDR_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [1:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_done,
    output logic              stall
`ifdef MEM_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } state_t;

    state_t            state;
    logic              st_q;
    logic              ind_q;
    logic [DATA_W-1:0] store_data_q;

    // Word accesses always go to the even byte of the word.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

    // Stall the detection cycle in IDLE so the instruction stays in EX/MEM,
    // and every cycle a request is outstanding. DONE lets the pipeline move.
    assign stall = ((state == IDLE) && valid && in_mem) ||
                   (state == ACC1) || (state == ACC2);

    // Sequencer FSM. All cache request signals are registered so they are
    // glitch-free and stay constant for the whole life of a request.
    // dmem_read/dmem_write are only ever set as a complementary pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            st_q             <= 1'b0;
            ind_q            <= 1'b0;
            store_data_q     <= '0;
            dmem_address     <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_byte_enable <= 2'b00;
            dmem_wdata       <= '0;
            load_data        <= '0;
            mem_done         <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && in_mem) begin
                        st_q         <= in_st;
                        ind_q        <= in_indirect;
                        store_data_q <= store_data;
                        state        <= ACC1;
                        if (in_indirect) begin
                            // Pointer fetch is always a word read, even for STI.
                            dmem_read    <= 1'b1;
                            dmem_write   <= 1'b0;
                            dmem_address <= word_align(addr);
                        end else if (in_st) begin
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b1;
                            if (in_byte) begin
                                // Byte lane picked by addr[0]; data replicated
                                // to both lanes so either lane sees the byte.
                                dmem_address     <= addr;
                                dmem_byte_enable <= addr[0] ? 2'b10 : 2'b01;
                                dmem_wdata       <= DATA_W'({2{store_data[7:0]}});
                            end else begin
                                dmem_address     <= word_align(addr);
                                dmem_byte_enable <= 2'b11;
                                dmem_wdata       <= store_data;
                            end
                        end else begin
                            dmem_read    <= 1'b1;
                            dmem_write   <= 1'b0;
                            dmem_address <= word_align(addr);
                        end
                    end
                end

                ACC1: begin
                    if (dmem_resp) begin
                        if (ind_q) begin
                            // Second access of LDI/STI goes to the fetched pointer.
                            dmem_address <= word_align(ADDR_W'(dmem_rdata));
                            dmem_read    <= ~st_q;
                            dmem_write   <= st_q;
                            if (st_q) begin
                                dmem_byte_enable <= 2'b11;
                                dmem_wdata       <= store_data_q;
                            end
                            state <= ACC2;
                        end else begin
                            if (dmem_read) begin
                                load_data <= dmem_rdata;
                            end
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b0;
                            mem_done   <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                ACC2: begin
                    if (dmem_resp) begin
                        if (dmem_read) begin
                            load_data <= dmem_rdata;
                        end
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        mem_done   <= 1'b1;
                        state      <= DONE;
                    end
                end

                // The finished instruction is still in EX/MEM this cycle, so
                // return to IDLE without looking at valid.
                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_SEQ_STALL_CNT_EN
    // Saturating count of stalled cycles, for performance monitoring.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// tb_mem_stage_sequencer
//
// Directed self-checking bench for mem_stage_sequencer. Each instruction's
// expected cache accesses are pushed to a scoreboard queue when it is issued
// and popped when the DUT raises a request. Inputs are driven and outputs
// sampled on the falling clock edge.

module tb_mem_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        in_mem;
    logic        in_st;
    logic        in_indirect;
    logic        in_byte;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic [15:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic [15:0] load_data;
    logic        mem_done;
    logic        stall;
`ifdef MEM_SEQ_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    mem_stage_sequencer #(
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .valid            (valid),
        .in_mem           (in_mem),
        .in_st            (in_st),
        .in_indirect      (in_indirect),
        .in_byte          (in_byte),
        .addr             (addr),
        .store_data       (store_data),
        .dmem_address     (dmem_address),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .load_data        (load_data),
        .mem_done         (mem_done),
        .stall            (stall)
`ifdef MEM_SEQ_STALL_CNT_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wd;
    } acc_t;

    acc_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   issue_cyc = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference for the first access of an instruction.
    function automatic acc_t model_first(input logic ind, input logic st, input logic byt,
                                         input logic [15:0] a, input logic [15:0] sd);
        acc_t r;
        r.a = {a[15:1], 1'b0};
        r.rd = 1'b0;
        r.wr = 1'b0;
        r.be = 2'b00;
        r.wd = 16'h0000;
        if (ind || !st) begin
            r.rd = 1'b1;
        end else begin
            r.wr = 1'b1;
            if (byt) begin
                r.a  = a;
                r.be = a[0] ? 2'b10 : 2'b01;
                r.wd = {sd[7:0], sd[7:0]};
            end else begin
                r.be = 2'b11;
                r.wd = sd;
            end
        end
        return r;
    endfunction

    // Reference for the access at the pointer of LDI/STI.
    function automatic acc_t model_second(input logic [15:0] ptr, input logic st,
                                          input logic [15:0] sd);
        acc_t r;
        r.a  = {ptr[15:1], 1'b0};
        r.rd = ~st;
        r.wr = st;
        r.be = st ? 2'b11 : 2'b00;
        r.wd = st ? sd : 16'h0000;
        return r;
    endfunction

    // Present an instruction in EX/MEM and queue its expected accesses.
    task automatic applyStimulus(input logic ind, input logic st, input logic byt,
                                 input logic [15:0] a, input logic [15:0] sd,
                                 input logic [15:0] ptr);
        valid       = 1'b1;
        in_mem      = 1'b1;
        in_indirect = ind;
        in_st       = st;
        in_byte     = byt;
        addr        = a;
        store_data  = sd;
        exp_q.push_back(model_first(ind, st, byt, a, sd));
        if (ind) exp_q.push_back(model_second(ptr, st, sd));
        issue_cyc = cyc;
    endtask

    // Wait for a request, compare it with the scoreboard, hold it for
    // 'waits' cycles checking stability, then respond with rdata.
    task automatic serve(input int waits, input logic [15:0] rdata, input string tag);
        acc_t e;
        int   n = 0;
        while (!(dmem_read || dmem_write) && n < 16) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " request seen"}, 32'(n < 16), 32'd1);
        checkOutput({tag, " scoreboard nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k <= waits; k++) begin
                if (k != 0) @(negedge clk);
                checkOutput({tag, " address"}, 32'(dmem_address), 32'(e.a));
                checkOutput({tag, " read"}, 32'(dmem_read), 32'(e.rd));
                checkOutput({tag, " write"}, 32'(dmem_write), 32'(e.wr));
                checkOutput({tag, " stall"}, 32'(stall), 32'd1);
                if (e.wr) begin
                    checkOutput({tag, " byte_enable"}, 32'(dmem_byte_enable), 32'(e.be));
                    checkOutput({tag, " wdata"}, 32'(dmem_wdata), 32'(e.wd));
                end
                dmem_resp = (k == waits);
                dmem_rdata = (k == waits) ? rdata : 16'hDEAD;
            end
        end
        @(negedge clk);
        dmem_resp  = 1'b0;
        dmem_rdata = 16'hDEAD;
    endtask

    // Checks in the DONE cycle.
    task automatic finishCheck(input string tag, input logic [15:0] exp_load, input int exp_lat);
        int n = 0;
        while (!mem_done && n < 16) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " mem_done"}, 32'(mem_done), 32'd1);
        checkOutput({tag, " latency"}, 32'(cyc - issue_cyc), 32'(exp_lat));
        checkOutput({tag, " done stall"}, 32'(stall), 32'd0);
        checkOutput({tag, " done no request"}, 32'(dmem_read | dmem_write), 32'd0);
        checkOutput({tag, " load_data"}, 32'(load_data), 32'(exp_load));
    endtask

    // Retire the instruction and check the following IDLE cycle.
    task automatic idleCheck(input string tag);
        valid  = 1'b0;
        in_mem = 1'b0;
        @(negedge clk);
        checkOutput({tag, " single mem_done"}, 32'(mem_done), 32'd0);
        checkOutput({tag, " idle stall"}, 32'(stall), 32'd0);
        checkOutput({tag, " idle no request"}, 32'(dmem_read | dmem_write), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        acc_t e;
        rst = 1'b1; valid = 1'b0; in_mem = 1'b0; in_st = 1'b0; in_indirect = 1'b0;
        in_byte = 1'b0; addr = 16'h0; store_data = 16'h0; dmem_rdata = 16'hDEAD;
        dmem_resp = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("reset read", 32'(dmem_read), 32'd0);
        checkOutput("reset write", 32'(dmem_write), 32'd0);
        checkOutput("reset address", 32'(dmem_address), 32'd0);
        checkOutput("reset byte_enable", 32'(dmem_byte_enable), 32'd0);
        checkOutput("reset wdata", 32'(dmem_wdata), 32'd0);
        checkOutput("reset load_data", 32'(load_data), 32'd0);
        checkOutput("reset mem_done", 32'(mem_done), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
`ifdef MEM_SEQ_STALL_CNT_EN
        checkOutput("reset stall_cycles", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // LDR at odd address, response on the first request cycle
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h1235, 16'h0000, 16'h0000);
        #1 checkOutput("ldr detect stall", 32'(stall), 32'd1);
        @(negedge clk);
        checkOutput("ldr aligned address", 32'(dmem_address), 32'h1234);
        serve(0, 16'hBEEF, "ldr");
        finishCheck("ldr", 16'hBEEF, 2);
`ifdef MEM_SEQ_STALL_CNT_EN
        checkOutput("ldr stall_cycles", stall_cycles, 32'd2);
`endif
        idleCheck("ldr");

        // ADD after LDR, with a stray response that must be ignored
        valid = 1'b1; in_mem = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'h1357;
        #1 checkOutput("add stall", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("add no request", 32'(dmem_read | dmem_write), 32'd0);
        checkOutput("add load_data kept", 32'(load_data), 32'hBEEF);
        checkOutput("add mem_done", 32'(mem_done), 32'd0);
        dmem_resp = 1'b0; valid = 1'b0;
        @(negedge clk);

        // STB to odd address, three wait cycles
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h2001, 16'h00A5, 16'h0000);
        @(negedge clk);
        checkOutput("stb byte_enable", 32'(dmem_byte_enable), 32'h2);
        checkOutput("stb wdata", 32'(dmem_wdata), 32'hA5A5);
        serve(3, 16'h0000, "stb");
        finishCheck("stb", 16'hBEEF, 5);
        idleCheck("stb");

        // LDI: pointer read then data read
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'h4000);
        serve(0, 16'h4000, "ldi ptr");
        serve(0, 16'h0042, "ldi data");
        finishCheck("ldi", 16'h0042, 3);
        idleCheck("ldi");

        // STI: pointer read (one wait), word write, then back-to-back LDR
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h3000, 16'h1111, 16'h5002);
        serve(1, 16'h5002, "sti ptr");
        serve(0, 16'h0000, "sti write");
        finishCheck("sti", 16'h0042, 4);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000);
        #1 checkOutput("b2b done stall", 32'(stall), 32'd0);
        @(negedge clk);
        issue_cyc = cyc;
        checkOutput("b2b detect stall", 32'(stall), 32'd1);
        checkOutput("b2b detect no request", 32'(dmem_read | dmem_write), 32'd0);
        serve(0, 16'h7777, "b2b ldr");
        finishCheck("b2b ldr", 16'h7777, 2);
        idleCheck("b2b ldr");

        // Reset in the second cycle of an outstanding STR
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0600, 16'hCAFE, 16'h0000);
        @(negedge clk);
        e = exp_q.pop_front();
        checkOutput("str write", 32'(dmem_write), 32'(e.wr));
        checkOutput("str address", 32'(dmem_address), 32'(e.a));
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; in_mem = 1'b0;
        @(negedge clk);
        checkOutput("rst write dropped", 32'(dmem_write), 32'd0);
        checkOutput("rst no read", 32'(dmem_read), 32'd0);
        checkOutput("rst stall", 32'(stall), 32'd0);
        checkOutput("rst mem_done", 32'(mem_done), 32'd0);
        checkOutput("rst load_data", 32'(load_data), 32'd0);
`ifdef MEM_SEQ_STALL_CNT_EN
        checkOutput("rst stall_cycles", stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post rst mem_done", 32'(mem_done), 32'd0);

        // LDR after reset proves the sequencer is back in IDLE
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000);
        #1 checkOutput("post rst detect stall", 32'(stall), 32'd1);
        serve(0, 16'h5555, "post rst ldr");
        finishCheck("post rst ldr", 16'h5555, 2);
        idleCheck("post rst ldr");

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
